// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler.
// Latches floor calls, picks the next destination with a LOOK policy, hands it
// to the motion controller with a valid/ready handshake, and retargets the car
// when a new call appears between its current floor and its destination.
module elevator_request_scheduler #(
    parameter int N_FLOORS = 4,
    parameter int FW       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_btn_i,
    input  logic [FW-1:0]       cur_floor_i,
    input  logic                serve_done_i,
    input  logic                target_ready_i,
    output logic [FW-1:0]       target_floor_o,
    output logic                target_valid_o,
    output logic [1:0]          dir_o,
    output logic [N_FLOORS-1:0] pending_o,
    output logic                busy_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_MOVING = 2'd3;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    logic [1:0]          state_q, state_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [FW-1:0]       target_floor_q, target_floor_d;
    logic                target_valid_q, target_valid_d;
    logic [1:0]          dir_q, dir_d;
    logic                busy_q;

    logic [N_FLOORS-1:0] cur_onehot_s;
    logic [N_FLOORS-1:0] clear_mask_s;
    logic [N_FLOORS-1:0] above_mask_s, below_mask_s;
    logic                above_found_s, below_found_s;
    logic [FW-1:0]       above_floor_s, below_floor_s;
    logic [FW-1:0]       dist_up_s, dist_dn_s;
    logic [FW-1:0]       look_floor_s;
    logic [1:0]          look_dir_s;
    logic                retarget_s;
    logic [FW-1:0]       retarget_floor_s;

    assign cur_onehot_s = {{(N_FLOORS-1){1'b0}}, 1'b1} << cur_floor_i;

    // Request latch: a serviced floor clears only on serve_done while moving; a new call wins over a clear.
    always_comb begin
        clear_mask_s = (state_q == ST_MOVING && serve_done_i) ? cur_onehot_s : {N_FLOORS{1'b0}};
        pending_d    = (pending_q & ~clear_mask_s) | call_btn_i;
    end

    // Nearest pending floor strictly above (lowest) and strictly below (highest) the car.
    always_comb begin
        above_floor_s = {FW{1'b0}};
        below_floor_s = {FW{1'b0}};
        for (int i = 0; i < N_FLOORS; i++) begin
            above_mask_s[i] = pending_q[i] && (FW'(i) > cur_floor_i);
            below_mask_s[i] = pending_q[i] && (FW'(i) < cur_floor_i);
        end
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            above_floor_s = above_mask_s[i] ? FW'(i) : above_floor_s;
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            below_floor_s = below_mask_s[i] ? FW'(i) : below_floor_s;
        end
        above_found_s = |above_mask_s;
        below_found_s = |below_mask_s;
        dist_up_s     = above_floor_s - cur_floor_i;
        dist_dn_s     = cur_floor_i - below_floor_s;
    end

    // LOOK choice: keep sweeping in the current direction, reverse only when nothing lies ahead.
    always_comb begin
        look_floor_s = cur_floor_i;
        look_dir_s   = DIR_IDLE;
        if (((dir_q == DIR_IDLE) && pending_q[cur_floor_i]) || (pending_q == cur_onehot_s)) begin
            look_floor_s = cur_floor_i;
            look_dir_s   = DIR_IDLE;
        end else begin
            case (dir_q)
                DIR_UP: begin
                    look_floor_s = above_found_s ? above_floor_s : below_floor_s;
                    look_dir_s   = above_found_s ? DIR_UP : DIR_DOWN;
                end
                DIR_DOWN: begin
                    look_floor_s = below_found_s ? below_floor_s : above_floor_s;
                    look_dir_s   = below_found_s ? DIR_DOWN : DIR_UP;
                end
                default: begin
                    // Idle car: nearest call, equal distance resolved upward.
                    if (above_found_s && (!below_found_s || (dist_up_s <= dist_dn_s))) begin
                        look_floor_s = above_floor_s;
                        look_dir_s   = DIR_UP;
                    end else begin
                        look_floor_s = below_floor_s;
                        look_dir_s   = DIR_DOWN;
                    end
                end
            endcase
        end
    end

    // Retarget detection: the nearest call ahead of the car that is short of the current destination.
    always_comb begin
        case (dir_q)
            DIR_UP: begin
                retarget_s       = above_found_s && (above_floor_s < target_floor_q);
                retarget_floor_s = above_floor_s;
            end
            DIR_DOWN: begin
                retarget_s       = below_found_s && (below_floor_s > target_floor_q);
                retarget_floor_s = below_floor_s;
            end
            default: begin
                retarget_s       = 1'b0;
                retarget_floor_s = target_floor_q;
            end
        endcase
    end

    // Scheduler FSM next-state and registered-output next values.
    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        target_valid_d = target_valid_q;
        dir_d          = dir_q;
        case (state_q)
            ST_IDLE: begin
                target_valid_d = 1'b0;
                dir_d          = DIR_IDLE;
                if (pending_q != {N_FLOORS{1'b0}}) begin
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (pending_q == {N_FLOORS{1'b0}}) begin
                    state_d        = ST_IDLE;
                    dir_d          = DIR_IDLE;
                    target_valid_d = 1'b0;
                end else begin
                    state_d        = ST_ISSUE;
                    target_floor_d = look_floor_s;
                    dir_d          = look_dir_s;
                    target_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                // Target and direction are frozen until the motion controller takes them.
                if (target_ready_i) begin
                    state_d        = ST_MOVING;
                    target_valid_d = 1'b0;
                end else begin
                    state_d        = ST_ISSUE;
                    target_valid_d = 1'b1;
                end
            end
            ST_MOVING: begin
                if (serve_done_i) begin
                    state_d = ST_SELECT;
                end else if (retarget_s) begin
                    state_d        = ST_ISSUE;
                    target_floor_d = retarget_floor_s;
                    target_valid_d = 1'b1;
                end else begin
                    state_d = ST_MOVING;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                target_valid_d = 1'b0;
                dir_d          = DIR_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every request and any unaccepted target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= {N_FLOORS{1'b0}};
            target_floor_q <= {FW{1'b0}};
            target_valid_q <= 1'b0;
            dir_q          <= DIR_IDLE;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_floor_q <= target_floor_d;
            target_valid_q <= target_valid_d;
            dir_q          <= dir_d;
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign target_floor_o = target_floor_q;
    assign target_valid_o = target_valid_q;
    assign dir_o          = dir_q;
    assign pending_o      = pending_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Testbench for elevator_request_scheduler: directed vector table, hand-written
// corner sequences and a long randomized run against a behavioural model.
module tb_elevator_request_scheduler;

    localparam int N  = 4;
    localparam int FW = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_SEL   = 1;
    localparam int PH_ISSUE = 2;
    localparam int PH_MOVE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  call_btn;
    logic [FW-1:0] cur_floor;
    logic          serve_done;
    logic          target_ready;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic [1:0]    dir;
    logic [N-1:0]  pending;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_phase = PH_IDLE;
    bit m_pend[N];
    int m_tgt   = 0;
    int m_dir   = 0;
    bit m_tv    = 1'b0;

    typedef struct {
        logic         rst;
        logic [N-1:0] call;
        logic [1:0]   cur;
        logic         serve;
        logic         ready;
        logic [N-1:0] e_pend;
        logic         e_tv;
        logic [1:0]   e_tgt;
        logic [1:0]   e_dir;
        logic         e_busy;
    } vec_t;

    vec_t tbl[20];

    elevator_request_scheduler #(.N_FLOORS(N), .FW(FW)) dut (
        .clk            (clk),
        .rst            (rst),
        .call_btn_i     (call_btn),
        .cur_floor_i    (cur_floor),
        .serve_done_i   (serve_done),
        .target_ready_i (target_ready),
        .target_floor_o (target_floor),
        .target_valid_o (target_valid),
        .dir_o          (dir),
        .pending_o      (pending),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [1:0] cf,
                                input logic s, input logic rd, input logic [3:0] ep,
                                input logic etv, input logic [1:0] et, input logic [1:0] ed,
                                input logic eb);
        vec_t v;
        v.rst = r; v.call = c; v.cur = cf; v.serve = s; v.ready = rd;
        v.e_pend = ep; v.e_tv = etv; v.e_tgt = et; v.e_dir = ed; v.e_busy = eb;
        return v;
    endfunction

    function automatic int pend_bits();
        int v = 0;
        for (int f = 0; f < N; f++) v += m_pend[f] ? (1 << f) : 0;
        return v;
    endfunction

    // LOOK destination from the list of pending floors
    function automatic void look(input int cur, input int dir_in, output int tgt, output int dir_out);
        int cnt = 0;
        int up  = -1;
        int dn  = -1;
        for (int f = 0; f < N; f++) if (m_pend[f]) cnt++;
        for (int d = 1; d < N; d++) begin
            if (up < 0 && cur + d < N && m_pend[cur + d]) up = cur + d;
            if (dn < 0 && cur - d >= 0 && m_pend[cur - d]) dn = cur - d;
        end
        if (m_pend[cur] && (dir_in == 0 || cnt == 1)) begin
            tgt = cur; dir_out = 0;
        end else if (dir_in == 1) begin
            if (up >= 0) begin tgt = up; dir_out = 1; end
            else begin tgt = dn; dir_out = 2; end
        end else if (dir_in == 2) begin
            if (dn >= 0) begin tgt = dn; dir_out = 2; end
            else begin tgt = up; dir_out = 1; end
        end else begin
            if (up >= 0 && (dn < 0 || (up - cur) <= (cur - dn))) begin tgt = up; dir_out = 1; end
            else begin tgt = dn; dir_out = 2; end
        end
    endfunction

    // advance the model by one clock using the currently driven inputs
    task automatic model_step();
        bit np[N];
        int n_phase = m_phase;
        int n_tgt   = m_tgt;
        int n_dir   = m_dir;
        bit n_tv    = m_tv;
        int cur     = int'(cur_floor);
        bit any     = 1'b0;
        int best    = -1;
        if (rst) begin
            for (int f = 0; f < N; f++) np[f] = 1'b0;
            n_phase = PH_IDLE; n_tgt = 0; n_dir = 0; n_tv = 1'b0;
        end else begin
            for (int f = 0; f < N; f++) begin
                np[f] = m_pend[f];
                if (m_phase == PH_MOVE && serve_done && f == cur) np[f] = 1'b0;
                if (call_btn[f]) np[f] = 1'b1;
                if (m_pend[f]) any = 1'b1;
            end
            case (m_phase)
                PH_IDLE: if (any) n_phase = PH_SEL;
                PH_SEL: begin
                    if (!any) begin
                        n_phase = PH_IDLE; n_dir = 0; n_tv = 1'b0;
                    end else begin
                        look(cur, m_dir, n_tgt, n_dir);
                        n_phase = PH_ISSUE; n_tv = 1'b1;
                    end
                end
                PH_ISSUE: if (target_ready) begin n_phase = PH_MOVE; n_tv = 1'b0; end
                default: begin
                    if (serve_done) begin
                        n_phase = PH_SEL;
                    end else begin
                        for (int f = 0; f < N; f++) begin
                            if (m_pend[f] &&
                                ((m_dir == 1 && f > cur && f < m_tgt) ||
                                 (m_dir == 2 && f < cur && f > m_tgt))) begin
                                if (best < 0 || (f > cur ? f - cur : cur - f) < (best > cur ? best - cur : cur - best))
                                    best = f;
                            end
                        end
                        if (best >= 0) begin
                            n_tgt = best; n_tv = 1'b1; n_phase = PH_ISSUE;
                        end
                    end
                end
            endcase
        end
        for (int f = 0; f < N; f++) m_pend[f] = np[f];
        m_phase = n_phase; m_tgt = n_tgt; m_dir = n_dir; m_tv = n_tv;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // one clock: update model, let the DUT clock, compare all outputs against the model
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_pending", int'(pending), pend_bits());
        check("model_target_floor", int'(target_floor), m_tgt);
        check("model_target_valid", int'(target_valid), int'(m_tv));
        check("model_dir", int'(dir), m_dir);
        check("model_busy", int'(busy), (m_phase != PH_IDLE) ? 1 : 0);
    endtask

    task automatic drive(input logic r, input logic [3:0] c, input logic [1:0] cf,
                         input logic s, input logic rd);
        rst = r; call_btn = c; cur_floor = cf; serve_done = s; target_ready = rd;
        cycle();
    endtask

    initial begin
        for (int f = 0; f < N; f++) m_pend[f] = 1'b0;
        rst = 1'b1; call_btn = '0; cur_floor = '0; serve_done = 1'b0; target_ready = 1'b0;

        //            rst call     cur  srv rdy | pend     tv   tgt   dir    busy
        tbl[0]  = mk(1, 4'b0000, 2'd0, 0, 0, 4'b0000, 0, 2'd0, 2'b00, 0);
        tbl[1]  = mk(0, 4'b0100, 2'd0, 0, 0, 4'b0100, 0, 2'd0, 2'b00, 0);
        tbl[2]  = mk(0, 4'b0000, 2'd0, 0, 0, 4'b0100, 0, 2'd0, 2'b00, 1);
        tbl[3]  = mk(0, 4'b0000, 2'd0, 0, 0, 4'b0100, 1, 2'd2, 2'b01, 1);
        tbl[4]  = mk(0, 4'b0000, 2'd0, 0, 1, 4'b0100, 0, 2'd2, 2'b01, 1);
        tbl[5]  = mk(0, 4'b0000, 2'd1, 0, 1, 4'b0100, 0, 2'd2, 2'b01, 1);
        tbl[6]  = mk(0, 4'b0000, 2'd2, 1, 0, 4'b0000, 0, 2'd2, 2'b01, 1);
        tbl[7]  = mk(0, 4'b0000, 2'd2, 0, 0, 4'b0000, 0, 2'd2, 2'b00, 0);
        tbl[8]  = mk(0, 4'b0100, 2'd2, 0, 0, 4'b0100, 0, 2'd2, 2'b00, 0);
        tbl[9]  = mk(0, 4'b0000, 2'd2, 1, 0, 4'b0100, 0, 2'd2, 2'b00, 1);
        tbl[10] = mk(0, 4'b0000, 2'd2, 0, 0, 4'b0100, 1, 2'd2, 2'b00, 1);
        tbl[11] = mk(0, 4'b0000, 2'd2, 0, 1, 4'b0100, 0, 2'd2, 2'b00, 1);
        tbl[12] = mk(0, 4'b0100, 2'd2, 1, 0, 4'b0100, 0, 2'd2, 2'b00, 1);
        tbl[13] = mk(0, 4'b0000, 2'd2, 0, 0, 4'b0100, 1, 2'd2, 2'b00, 1);
        tbl[14] = mk(0, 4'b0000, 2'd2, 0, 1, 4'b0100, 0, 2'd2, 2'b00, 1);
        tbl[15] = mk(0, 4'b1010, 2'd2, 1, 0, 4'b1010, 0, 2'd2, 2'b00, 1);
        tbl[16] = mk(0, 4'b0000, 2'd2, 0, 0, 4'b1010, 1, 2'd3, 2'b01, 1);
        tbl[17] = mk(0, 4'b0000, 2'd2, 0, 1, 4'b1010, 0, 2'd3, 2'b01, 1);
        tbl[18] = mk(1, 4'b0010, 2'd2, 0, 0, 4'b0000, 0, 2'd0, 2'b00, 0);
        tbl[19] = mk(0, 4'b0001, 2'd2, 0, 0, 4'b0001, 0, 2'd0, 2'b00, 0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].call, tbl[i].cur, tbl[i].serve, tbl[i].ready);
            check($sformatf("tbl%0d_pending", i), int'(pending), int'(tbl[i].e_pend));
            check($sformatf("tbl%0d_valid", i), int'(target_valid), int'(tbl[i].e_tv));
            check($sformatf("tbl%0d_target", i), int'(target_floor), int'(tbl[i].e_tgt));
            check($sformatf("tbl%0d_dir", i), int'(dir), int'(tbl[i].e_dir));
            check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
        end

        // LOOK keeps going up past a lower call, then reverses
        drive(1, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b0010, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 1);
        drive(0, 4'b1001, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd1, 1, 0);
        drive(0, 4'b0000, 2'd1, 0, 0);
        check("look_up_target", int'(target_floor), 3);
        check("look_up_dir", int'(dir), 1);
        drive(0, 4'b0000, 2'd1, 0, 1);
        drive(0, 4'b0000, 2'd3, 1, 0);
        drive(0, 4'b0000, 2'd3, 0, 0);
        check("look_rev_target", int'(target_floor), 0);
        check("look_rev_dir", int'(dir), 2);
        check("look_rev_valid", int'(target_valid), 1);

        // retarget to an intermediate call, then resume to the original destination
        drive(1, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b1000, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 0);
        drive(0, 4'b0000, 2'd0, 0, 1);
        drive(0, 4'b0100, 2'd1, 0, 0);
        drive(0, 4'b0000, 2'd1, 0, 0);
        check("retarget_target", int'(target_floor), 2);
        check("retarget_valid", int'(target_valid), 1);
        drive(0, 4'b0000, 2'd1, 0, 1);
        drive(0, 4'b0000, 2'd2, 1, 0);
        check("retarget_pending", int'(pending), 4'b1000);
        drive(0, 4'b0000, 2'd2, 0, 0);
        check("resume_target", int'(target_floor), 3);

        // handshake stall: target held stable until accepted
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'b0000, 2'd2, 0, 0);
            check("stall_valid", int'(target_valid), 1);
            check("stall_target", int'(target_floor), 3);
        end
        drive(0, 4'b0000, 2'd2, 0, 1);
        check("stall_release_valid", int'(target_valid), 0);
        check("stall_release_busy", int'(busy), 1);

        // randomized run against the model
        drive(1, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom % 150) == 0;
            call_btn     = (($urandom % 6) == 0) ? 4'($urandom % 16) : 4'b0000;
            cur_floor    = (($urandom % 3) == 0) ? 2'($urandom_range(0, 3)) : cur_floor;
            serve_done   = ($urandom % 5) == 0;
            target_ready = ($urandom % 2) == 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 The block SHALL have parameter N_FLOORS, default 4, number of serviced floors (floors 0..N_FLOORS-1); only value 4 is supported.
REQ-002 The block SHALL have parameter FW, default 2, floor index width; FW SHALL equal clog2(N_FLOORS).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 call_btn  input  N_FLOORS  floor request buttons, level-sampled every cycle; bit i = floor i.
REQ-006 cur_floor  input  FW  current car floor from motion controller.
REQ-007 serve_done  input  1  one-cycle pulse: car stopped at cur_floor and door cycle finished.
REQ-008 target_ready  input  1  motion controller accepts target_floor.
REQ-009 target_floor  output  FW  commanded destination floor, registered.
REQ-010 target_valid  output  1  target_floor is valid; registered.
REQ-011 dir  output  2  travel direction, registered: 00 idle, 01 up, 10 down; 11 never driven.
REQ-012 pending  output  N_FLOORS  latched outstanding requests.
REQ-013 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 pending[i] SHALL set on the cycle after call_btn[i] is sampled high and hold until cleared.
REQ-015 pending[cur_floor] SHALL clear on the cycle after serve_done is sampled high in MOVING; serve_done SHALL be ignored in all other states.
REQ-016 On a same-cycle set and clear of one bit, set SHALL win.
REQ-017 FSM states SHALL be IDLE, SELECT, ISSUE, MOVING.
REQ-018 IDLE: dir=00, target_valid=0; on pending!=0 -> SELECT next cycle.
REQ-019 SELECT, one cycle: compute target by LOOK rule (REQ-020..022), load target_floor and dir, -> ISSUE; if pending==0 -> IDLE with dir=00.
REQ-020 If dir=01: target = lowest pending floor > cur_floor; if none, highest pending floor < cur_floor with dir=10.
REQ-021 If dir=10: target = highest pending floor < cur_floor; if none, lowest pending floor > cur_floor with dir=01.
REQ-022 If dir=00, or pending[cur_floor] is the only pending bit: pending[cur_floor] wins first (dir=00); else nearest pending floor, tie -> up (dir=01).
REQ-023 ISSUE: target_valid=1; target_floor and dir SHALL stay stable until target_valid&&target_ready; on transfer -> MOVING, target_valid=0 next cycle.
REQ-024 MOVING: if a pending floor lies strictly between cur_floor and target_floor in direction dir, -> ISSUE with target_floor = that floor (nearest to cur_floor) on the next cycle (retarget).
REQ-025 MOVING: serve_done -> SELECT; dir retained as input to LOOK.
REQ-026 Latency: call_btn sampled at edge k with FSM IDLE -> pending at k+1, SELECT at k+2, target_valid=1 at k+3.
REQ-027 target_floor SHALL always be < N_FLOORS; FW-bit comparisons SHALL be unsigned.

Reset
REQ-028 While rst is high: state=IDLE, pending=0, target_floor=0, target_valid=0, dir=00, busy=0; call_btn and serve_done ignored.
REQ-029 rst asserted mid-operation (any state) SHALL discard all pending requests and any un-accepted target within one cycle.

Verification
REQ-030 Idle, cur_floor=0, call_btn=0100 one cycle, target_ready=1 -> target_valid=1 at k+3, target_floor=2, dir=01; MOVING; serve_done with cur_floor=2 -> pending=0000, IDLE, dir=00.
REQ-031 cur_floor=1, dir=01, pending={0,3} -> target_floor=3, dir=01; after serving floor 3 -> target_floor=0, dir=10.
REQ-032 MOVING 0->3, cur_floor=1, call_btn[2] pulses -> ISSUE with target_floor=2; floor 3 still pending after serving 2 -> target_floor=3.
REQ-033 ISSUE, target_ready=0 for 5 cycles -> target_valid=1 and target_floor unchanged all 5 cycles; transfer on cycle 6.
REQ-034 serve_done and call_btn[cur_floor] same cycle -> pending[cur_floor] stays 1; serve_done in IDLE -> pending unchanged.
REQ-035 rst for one cycle in MOVING with pending=1010 -> next cycle pending=0000, target_valid=0, dir=00, busy=0.
